// File: rtl/gcd_req_scheduler.sv
// Round-robin front end that shares one GCD core between N_REQ requesters.
// Zero-operand jobs are answered locally; a watchdog aborts jobs the core never finishes.
module gcd_req_scheduler #(
    parameter int N_REQ   = 4,
    parameter int W       = 10,
    parameter int TIMEOUT = 2048
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [W-1:0]       resp_res,
    output logic               resp_err,
    output logic               busy,
    output logic               gcd_start,
    output logic [W-1:0]       gcd_a,
    output logic [W-1:0]       gcd_b,
    input  logic               gcd_done,
    input  logic [W-1:0]       gcd_res
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]    WD_LAST  = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          j;
        res = {1'b0, ptr};
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!res[IW] && r[j]) begin
                res = {1'b1, IW'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_e             state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      wd_q, wd_d;
    logic [W-1:0]       gcd_a_q, gcd_a_d;
    logic [W-1:0]       gcd_b_q, gcd_b_d;
    logic               gcd_start_q, gcd_start_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [W-1:0]       resp_res_q, resp_res_d;
    logic               resp_err_q, resp_err_d;
    logic               busy_q, busy_d;

    logic [IW:0]        pick_s;
    logic               found_s;
    logic [IW-1:0]      sel_s;
    logic [W-1:0]       sel_a_s;
    logic [W-1:0]       sel_b_s;
    logic [N_REQ-1:0]   grant_s;

    // Arbitration: candidate requester and its operands for this IDLE cycle.
    always_comb begin
        pick_s  = rr_pick(req, rr_q);
        found_s = pick_s[IW];
        sel_s   = pick_s[IW-1:0];
        sel_a_s = req_a[sel_s*W +: W];
        sel_b_s = req_b[sel_s*W +: W];
        // Grant is combinational so operands are sampled on the same edge; held low in reset.
        if (state_q == IDLE && found_s && reset) begin
            grant_s = ONE_HOT0 << sel_s;
        end else begin
            grant_s = {N_REQ{1'b0}};
        end
    end

    // Next-state and registered-output computation for the job FSM.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        idx_d        = idx_q;
        wd_d         = wd_q;
        gcd_a_d      = gcd_a_q;
        gcd_b_d      = gcd_b_q;
        gcd_start_d  = 1'b0;
        resp_valid_d = {N_REQ{1'b0}};
        resp_res_d   = ZERO_W;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    idx_d = sel_s;
                    if (sel_a_s == ZERO_W || sel_b_s == ZERO_W) begin
                        state_d      = RESP;
                        resp_valid_d = ONE_HOT0 << sel_s;
                        resp_res_d   = sel_a_s | sel_b_s;
                    end else begin
                        state_d     = ISSUE;
                        gcd_a_d     = sel_a_s;
                        gcd_b_d     = sel_b_s;
                        gcd_start_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wd_d    = {CW{1'b0}};
            end
            WAIT: begin
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (gcd_done) begin
                    state_d      = RESP;
                    resp_valid_d = ONE_HOT0 << idx_q;
                    resp_res_d   = gcd_res;
                    gcd_a_d      = ZERO_W;
                    gcd_b_d      = ZERO_W;
                end else if (wd_q == WD_LAST) begin
                    state_d      = RESP;
                    resp_valid_d = ONE_HOT0 << idx_q;
                    resp_err_d   = 1'b1;
                    gcd_a_d      = ZERO_W;
                    gcd_b_d      = ZERO_W;
                end else begin
                    wd_d = wd_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                state_d = IDLE;
                rr_d    = (idx_q == IDX_LAST) ? {IW{1'b0}} : idx_q + {{(IW-1){1'b0}}, 1'b1};
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_q         <= {IW{1'b0}};
            idx_q        <= {IW{1'b0}};
            wd_q         <= {CW{1'b0}};
            gcd_a_q      <= ZERO_W;
            gcd_b_q      <= ZERO_W;
            gcd_start_q  <= 1'b0;
            resp_valid_q <= {N_REQ{1'b0}};
            resp_res_q   <= ZERO_W;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            idx_q        <= idx_d;
            wd_q         <= wd_d;
            gcd_a_q      <= gcd_a_d;
            gcd_b_q      <= gcd_b_d;
            gcd_start_q  <= gcd_start_d;
            resp_valid_q <= resp_valid_d;
            resp_res_q   <= resp_res_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign grant      = grant_s;
    assign resp_valid = resp_valid_q;
    assign resp_res   = resp_res_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign gcd_start  = gcd_start_q;
    assign gcd_a      = gcd_a_q;
    assign gcd_b      = gcd_b_q;

endmodule

// File: tb/tb_gcd_req_scheduler.sv
// Directed bench for gcd_req_scheduler with a behavioural GCD core of programmable latency.
module tb_gcd_req_scheduler;
    localparam int N  = 4;
    localparam int W  = 10;
    localparam int TO = 2048;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_res;
    logic           resp_err;
    logic           busy;
    logic           gcd_start;
    logic [W-1:0]   gcd_a;
    logic [W-1:0]   gcd_b;
    logic           gcd_done;
    logic [W-1:0]   gcd_res;

    int total = 0;
    int bad = 0;

    // Core model: m_lat = cycles from start to done (0 = never finishes).
    int           m_lat = 0;
    int           m_cnt = 0;
    logic         model_done = 1'b0;
    logic [W-1:0] model_res = '0;
    logic         tb_done = 1'b0;

    assign gcd_done = model_done | tb_done;
    assign gcd_res  = model_res;

    gcd_req_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .grant(grant), .resp_valid(resp_valid), .resp_res(resp_res), .resp_err(resp_err),
        .busy(busy), .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_done(gcd_done), .gcd_res(gcd_res)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        if (m_cnt == 1) begin
            model_done <= 1'b1;
            model_res  <= gcd_fn(gcd_a, gcd_b);
        end else begin
            model_done <= 1'b0;
        end
        if (gcd_start) m_cnt <= m_lat;
        else if (m_cnt > 0) m_cnt <= m_cnt - 1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        total++;
        if ({grant, resp_valid, resp_res, resp_err, busy, gcd_start, gcd_a, gcd_b} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: grant=%b rv=%b res=%0d err=%b busy=%b start=%b a=%0d b=%0d, want all 0",
                     grant, resp_valid, resp_res, resp_err, busy, gcd_start, gcd_a, gcd_b);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release: busy=%b grant=%b, want 0/0000", busy, grant);
        end
    endtask

    task automatic test_single();
        m_lat = 3;
        next_cycle();
        req = 4'b0001;
        req_a[9:0] = 10'd10;
        req_b[9:0] = 10'd5;
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", grant); end
        next_cycle();
        req = 4'b0000;
        req_a[9:0] = 10'd99;
        req_b[9:0] = 10'd33;
        @(negedge clk);
        total++;
        if (gcd_start !== 1'b1 || gcd_a !== 10'd10 || gcd_b !== 10'd5 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_start: start=%b a=%0d b=%0d busy=%b want 1/10/5/1", gcd_start, gcd_a, gcd_b, busy);
        end
        for (int k = 2; k <= 4; k++) begin
            next_cycle();
            @(negedge clk);
            total++;
            if (resp_valid !== 4'b0000 || gcd_start !== 1'b0 || gcd_a !== 10'd10) begin
                bad++;
                $display("FAIL single_wait%0d: rv=%b start=%b a=%0d want 0000/0/10", k, resp_valid, gcd_start, gcd_a);
            end
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (resp_valid !== 4'b0001 || resp_res !== 10'd5 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL single_resp: rv=%b res=%0d err=%b want 0001/5/0", resp_valid, resp_res, resp_err);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (resp_valid !== 4'b0000 || resp_res !== 10'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_after: rv=%b res=%0d busy=%b want 0000/0/0", resp_valid, resp_res, busy);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] exp_res[4] = '{10'd6, 10'd3, 10'd7, 10'd4};
        int ngrant = 0;
        int gi;
        int ri;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        m_lat = 1;
        req_a = {10'd8, 10'd14, 10'd9, 10'd12};
        req_b = {10'd20, 10'd21, 10'd6, 10'd18};
        req = 4'b1111;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (grant !== 4'b0000) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (grant[i]) gi = i;
                total++;
                if (!$onehot(grant) || gi != exp_order[ngrant]) begin
                    bad++;
                    $display("FAIL rr_grant%0d: got %b want index %0d one-hot", ngrant, grant, exp_order[ngrant]);
                end
                ngrant++;
            end
            if (resp_valid !== 4'b0000) begin
                ri = 0;
                for (int i = 0; i < N; i++) if (resp_valid[i]) ri = i;
                total++;
                if (resp_res !== exp_res[ri] || resp_err !== 1'b0) begin
                    bad++;
                    $display("FAIL rr_resp%0d: res=%0d err=%b want %0d/0", ri, resp_res, resp_err, exp_res[ri]);
                end
            end
            if (ngrant == 5) break;
            next_cycle();
        end
        total++;
        if (ngrant != 5) begin bad++; $display("FAIL rr_count: got %0d grants want 5", ngrant); end
        next_cycle();
        req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_bypass();
        logic [W-1:0] va[3] = '{10'd0, 10'd5, 10'd0};
        logic [W-1:0] vb[3] = '{10'd10, 10'd0, 10'd0};
        logic [W-1:0] ve[3] = '{10'd10, 10'd5, 10'd0};
        wait_idle();
        for (int v = 0; v < 3; v++) begin
            next_cycle();
            req = 4'b0100;
            req_a[29:20] = va[v];
            req_b[29:20] = vb[v];
            @(negedge clk);
            total++;
            if (grant !== 4'b0100 || gcd_start !== 1'b0) begin
                bad++;
                $display("FAIL bypass_grant%0d: grant=%b start=%b want 0100/0", v, grant, gcd_start);
            end
            next_cycle();
            req = 4'b0000;
            @(negedge clk);
            total++;
            if (resp_valid !== 4'b0100 || resp_res !== ve[v] || resp_err !== 1'b0 || gcd_start !== 1'b0) begin
                bad++;
                $display("FAIL bypass_resp%0d: rv=%b res=%0d err=%b start=%b want 0100/%0d/0/0",
                         v, resp_valid, resp_res, resp_err, gcd_start, ve[v]);
            end
            next_cycle();
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || gcd_start !== 1'b0) begin
                bad++;
                $display("FAIL bypass_idle%0d: busy=%b start=%b want 0/0", v, busy, gcd_start);
            end
        end
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        int n = 0;
        wait_idle();
        m_lat = 0;
        next_cycle();
        req = 4'b0010;
        req_a[19:10] = 10'd7;
        req_b[19:10] = 10'd21;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010) begin bad++; $display("FAIL to_grant: got %b want 0010", grant); end
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        for (int k = 2; k <= TO + 1; k++) begin
            next_cycle();
            @(negedge clk);
            if (resp_valid !== 4'b0000) early = 1'b1;
            if (k == 2) begin
                total++;
                if (gcd_a !== 10'd7 || gcd_b !== 10'd21 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL to_hold: a=%0d b=%0d busy=%b want 7/21/1", gcd_a, gcd_b, busy);
                end
            end
        end
        total++;
        if (early !== 1'b0) begin bad++; $display("FAIL to_early: early response seen=%b want 0", early); end
        next_cycle();
        @(negedge clk);
        total++;
        if (resp_valid !== 4'b0010 || resp_err !== 1'b1 || resp_res !== 10'd0) begin
            bad++;
            $display("FAIL to_resp: rv=%b err=%b res=%0d want 0010/1/0", resp_valid, resp_err, resp_res);
        end
        wait_idle();
        m_lat = 2;
        next_cycle();
        req = 4'b0010;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010) begin bad++; $display("FAIL to_next_grant: got %b want 0010", grant); end
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        while (resp_valid === 4'b0000 && n < 20) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        total++;
        if (resp_valid !== 4'b0010 || resp_res !== 10'd7 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL to_next_resp: rv=%b res=%0d err=%b want 0010/7/0", resp_valid, resp_res, resp_err);
        end
    endtask

    task automatic test_reset_in_wait();
        int n = 0;
        wait_idle();
        m_lat = 0;
        next_cycle();
        req = 4'b0001;
        req_a[9:0] = 10'd9;
        req_b[9:0] = 10'd6;
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL rw_grant: got %b want 0001", grant); end
        next_cycle();
        req = 4'b0000;
        next_cycle();
        next_cycle();
        #2;
        req = 4'b1001;
        reset = 1'b0;
        #1;
        total++;
        if ({grant, resp_valid, resp_res, resp_err, busy, gcd_start, gcd_a, gcd_b} !== '0) begin
            bad++;
            $display("FAIL rw_async: grant=%b rv=%b res=%0d err=%b busy=%b start=%b a=%0d b=%0d, want all 0",
                     grant, resp_valid, resp_res, resp_err, busy, gcd_start, gcd_a, gcd_b);
        end
        tb_done = 1'b1;
        next_cycle();
        tb_done = 1'b0;
        req = 4'b0000;
        next_cycle();
        reset = 1'b1;
        tb_done = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || resp_valid !== 4'b0000) begin
            bad++;
            $display("FAIL rw_late_done: busy=%b rv=%b want 0/0000", busy, resp_valid);
        end
        next_cycle();
        tb_done = 1'b0;
        m_lat = 1;
        req = 4'b1001;
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL rw_first: got %b want 0001", grant); end
        next_cycle();
        req = 4'b1000;
        @(negedge clk);
        while (grant === 4'b0000 && n < 20) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        total++;
        if (grant !== 4'b1000) begin bad++; $display("FAIL rw_second: got %b want 1000", grant); end
        next_cycle();
        req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_coincide();
        m_lat = TO;
        next_cycle();
        req = 4'b0001;
        req_a[9:0] = 10'd20;
        req_b[9:0] = 10'd6;
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL co_grant: got %b want 0001", grant); end
        next_cycle();
        req = 4'b0000;
        for (int k = 2; k <= TO + 1; k++) next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (resp_valid !== 4'b0001 || resp_res !== 10'd2 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL co_resp: rv=%b res=%0d err=%b want 0001/2/0", resp_valid, resp_res, resp_err);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_bypass();
        test_timeout();
        test_reset_in_wait();
        test_coincide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
